// File: rtl/sat_acc_seq_pkg.sv
// Shared types and constants for the saturating accumulate sequencer.
// Contents: FSM state enum, default widths, saturation bound helpers.
// Pure declarations; no logic, no latency, no flow control.
package rpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_W     = 6;
  localparam int DEF_LEN_W = 8;

  // Largest positive value of a w-bit two's complement number.
  function automatic int sat_max(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  // Most negative value of a w-bit two's complement number.
  function automatic int sat_min(input int w);
    return -(1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_acc_seq_sat_add3.sv
// Combinational 3-input signed saturating adder: sum = sat(x + y + z).
// Ports: x, y, z [W-1:0] signed operands; sum [W-1:0] clamped result; ovf high when clamped.
// Latency: zero (pure combinational); no flow control.
module sat_add3
  import rpu_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic [W-1:0] MIN_V = W'(sat_min(W));

  logic [W+1:0] full;
  logic [2:0]   top;

  // Two guard bits are enough for the exact sum of three W-bit operands.
  assign full = {{2{x[W-1]}}, x} + {{2{y[W-1]}}, y} + {{2{z[W-1]}}, z};
  assign top  = full[W+1:W-1];

  // The top three bits agree in sign with bit W-1 only when the result fits.
  always_comb begin
    sum = full[W-1:0];
    ovf = 1'b0;
    case (top)
      3'b001, 3'b010: begin
        sum = MAX_V;
        ovf = 1'b1;
      end
      3'b101, 3'b110: begin
        sum = MIN_V;
        ovf = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sat_acc_seq.sv
// Sequencer: folds len operand pairs into acc <= sat(acc + a + b), then presents the result.
// Ports: clk, rst (sync, active-low), start/len/busy control, in_valid/in_ready/in_a/in_b
//   operand stream, out_valid/out_ready/out_sum/sat_flag result. Optional abort input
//   when SAT_ACC_SEQ_ABORT_EN is defined.
// Latency: out_valid the cycle after the last pair handshake; one pair per cycle;
//   result held stable while out_ready is low, operand stream stalls on in_valid low.
module sat_acc_seq
  import rpu_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SAT_ACC_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             sat_flag
);

  state_t           state, state_nxt;
  logic [W-1:0]     acc, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_r, len_r_nxt;
  logic             sat, sat_nxt;

  logic [W-1:0]     step_sum;
  logic             step_ovf;

  // Accumulator is fed back as the first operand.
  sat_add3 #(.W(W)) u_add (
    .x   (acc),
    .y   (in_a),
    .z   (in_b),
    .sum (step_sum),
    .ovf (step_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_r <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len_r <= len_r_nxt;
      sat   <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_r_nxt = len_r;
    sat_nxt   = sat;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt = '0;
          sat_nxt = 1'b0;
          if (len != '0) begin
            len_r_nxt = len;
            cnt_nxt   = '0;
            state_nxt = ACC;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_nxt = step_sum;
          sat_nxt = sat | step_ovf;
          cnt_nxt = cnt + LEN_W'(1);
          // len_r is never zero here, so len_r-1 cannot underflow and cnt never wraps.
          if (cnt == len_r - LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef SAT_ACC_SEQ_ABORT_EN
    // Abort overrides any handshake in the same cycle.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      sat_nxt   = 1'b0;
    end
`endif
  end

  // All outputs come straight from registers so nothing is combinational from inputs.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign sat_flag  = sat;

endmodule

// File: tb/tb_sat_acc_seq.sv
module tb_sat_acc_seq;

  localparam int W     = 6;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             sat_flag;
`ifdef SAT_ACC_SEQ_ABORT_EN
  logic             abort;
`endif

  int checks = 0;
  int errors = 0;

  int exp_sum_q[$];
  int exp_flag_q[$];
  int pa[$];
  int pb[$];

  always #5 clk = ~clk;

  sat_acc_seq #(.W(W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SAT_ACC_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .sat_flag  (sat_flag)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Result monitor: a result is consumed when out_valid && out_ready at the next edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_sum_q.size() == 0) begin
        check_eq("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        int es, ef;
        es = exp_sum_q.pop_front();
        ef = exp_flag_q.pop_front();
        check_eq("sb_sum", {26'd0, out_sum}, 32'(es & 63));
        check_eq("sb_flag", {31'd0, sat_flag}, 32'(ef));
      end
    end
  end

  // Runs one reduction over the pairs in pa/pb. gap inserts an idle cycle between
  // pairs; rdy_delay holds out_ready low that many cycles; start_in_done pulses start in DONE.
  task automatic reduce(input int gap, input int rdy_delay, input bit start_in_done);
    int n, acc, flag, t;
    n = pa.size();
    acc = 0;
    flag = 0;
    for (int i = 0; i < n; i++) begin
      acc = acc + pa[i] + pb[i];
      if (acc > 31) begin acc = 31; flag = 1; end
      else if (acc < -32) begin acc = -32; flag = 1; end
    end
    exp_sum_q.push_back(acc);
    exp_flag_q.push_back(flag);

    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) check_eq("zero_len_in_ready", {31'd0, in_ready}, 32'd0);
    else        check_eq("acc_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a = W'(pa[i]);
      in_b = W'(pb[i]);
      t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) check_eq("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gap != 0 && i != n - 1) begin
        check_eq("gap_hold_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
      end
    end

    check_eq("out_valid_latency", {31'd0, out_valid}, 32'd1);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) check_eq("out_valid_timeout", 32'd0, 32'd1);

    for (int k = 0; k < rdy_delay; k++) begin
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_out_sum", {26'd0, out_sum}, 32'(acc & 63));
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (start_in_done) begin start = 1'b1; len = 8'd5; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("busy_drop", {31'd0, busy}, 32'd0);
    check_eq("out_valid_drop", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("idle_stays", {31'd0, busy}, 32'd0);
    pa.delete();
    pb.delete();
  endtask

  // Starts len=3, completes one handshake, and leaves the block mid-ACC.
  task automatic start_partial();
    start = 1'b1;
    len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 6'd9;
    in_b = 6'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("partial_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check_eq({pfx, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({pfx, "_out_sum"}, {26'd0, out_sum}, 32'd0);
    check_eq({pfx, "_sat_flag"}, {31'd0, sat_flag}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
`ifdef SAT_ACC_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Normal reduction, back-to-back: 20, 30, 31.
    pa = '{10, 5, 1};  pb = '{10, 5, 0};
    reduce(0, 0, 1'b0);

    // Per-step saturation: clamp to 31, then 26.
    pa = '{20, -5};    pb = '{20, 0};
    reduce(0, 0, 1'b0);

    // Negative clamp.
    pa = '{-32};       pb = '{-32};
    reduce(0, 0, 1'b0);

    // Zero length; start pulsed while in DONE must be ignored.
    reduce(0, 2, 1'b1);

    // Backpressure on both sides: 1, 15, 6, 14.
    pa = '{3, 7, -10, 4};  pb = '{-2, 7, 1, 4};
    reduce(1, 5, 1'b0);

    // Mid-operation reset.
    start_partial();
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef SAT_ACC_SEQ_ABORT_EN
    start_partial();
    abort = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    check_all_zero("abort");
    pa = '{3};  pb = '{4};
    reduce(0, 0, 1'b0);
`endif

    // Longer random reduction exercising both clamps along the way.
    for (int i = 0; i < 12; i++) begin
      pa.push_back(int'($urandom_range(63)) - 32);
      pb.push_back(int'($urandom_range(63)) - 32);
    end
    reduce(0, 1, 1'b0);

    check_eq("sb_drained", 32'(exp_sum_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
